vs_debouncer: RTL and testbench
===============================

Name: vs_debouncer

Overview:
- Synchronises and debounces an asynchronous, noisy level input (switch, button, external strobe). Produces a clean level and one-cycle rise/fall pulses.
- Sits directly upstream of the library's latch primitives: rise/fall are the clean set/reset sources for an SR latch, and dout is a clean data/enable source for a D latch.
- Also counts rejected glitches, for bring-up diagnostics.

Parameters:
- SYNC_STAGES, 2: synchroniser flop depth; legal values are 2 or more.
- STABLE_CYCLES, 4: number of consecutive identical synchronised samples needed to accept a new level; legal values are 1 or more.
- GLITCH_W, 8: width of the saturating glitch counter.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: reset is synchronous and active-high.
- din, input, 1: raw asynchronous input.
- dout, output, 1: debounced level.
- rise, output, 1: one-cycle pulse, asserted in the cycle dout goes 0->1.
- fall, output, 1: one-cycle pulse, asserted in the cycle dout goes 1->0.
- busy, output, 1: high while a level change is pending qualification.
- glitch_cnt, output, GLITCH_W: saturating count of rejected candidate transitions.

Behaviour:
- Reset (rst=1 at a clk edge):
  - synchroniser flops, dout, rise, fall, busy and glitch_cnt all go to 0.
  - state goes to S_LOW; qualification counter cnt goes to 0.
  - rst has priority over every other event, including a pending qualification, which is discarded without counting a glitch.
- Synchroniser: din passes through SYNC_STAGES flops; the last stage is din_s. Only din_s feeds the FSM.
- cnt width is $clog2(STABLE_CYCLES+1).
- FSM states:
  - S_LOW: dout=0. If din_s=1: when STABLE_CYCLES==1, go to S_HIGH and pulse rise; otherwise go to S_RISE_PEND with cnt=1.
  - S_RISE_PEND: dout=0, busy=1.
    - din_s=0: go to S_LOW, cnt=0, glitch_cnt+1.
    - din_s=1 and cnt==STABLE_CYCLES-1: go to S_HIGH, cnt=0, pulse rise.
    - otherwise: cnt+1.
  - S_HIGH and S_FALL_PEND mirror S_LOW and S_RISE_PEND, with polarities swapped and fall in place of rise.
- All outputs are registered.
- dout, rise and fall change at the same edge; rise/fall are high for exactly one cycle.
- busy is high exactly while in a PEND state.
- Latency: if din changes before edge E and stays stable, dout changes at edge E+SYNC_STAGES+STABLE_CYCLES-1, i.e. visible in the cycle after that edge. This is SYNC_STAGES+STABLE_CYCLES edges counting E.
- Acceptance rule: din_s must hold the new value for STABLE_CYCLES consecutive samples. A pulse one sample shorter is rejected and counts as exactly one glitch.
- glitch_cnt saturates at 2^GLITCH_W-1 and never wraps; only rst clears it.
- rise and fall are never both high.
- No more than one transition is accepted per STABLE_CYCLES cycles.

Decomposition:
- Package vs_debounce_pkg holds:
  - typedef enum logic [1:0] vs_db_state_t with {S_LOW, S_RISE_PEND, S_HIGH, S_FALL_PEND};
  - the width helper function for cnt.
- Sub-module vs_sync_ff (parameter STAGES; ports clk, rst, d, q) implements the synchroniser chain. It is reusable elsewhere in the library.

Test Plan:
All scenarios use SYNC_STAGES=2 and STABLE_CYCLES=4 unless stated.
- Reset: hold rst for 2 edges with din=1 -> dout=0, rise=0, fall=0, busy=0, glitch_cnt=0. After release, rise pulses at edge 6 and dout=1.
- Clean edges:
  - din 0->1 before edge 1, then held -> busy high after edges 3-5; rise=1 for one cycle and dout=1 after edge 6.
  - din 1->0 later -> fall pulse after the same 6-edge latency; rise stays 0.
- Glitches:
  - din high for 3 cycles then low -> dout stays 0, no rise, glitch_cnt=1.
  - Repeat with 4 cycles -> rise fires, dout=1.
- Saturation: GLITCH_W=2, five 2-cycle glitches -> glitch_cnt reads 1,2,3,3,3; dout stays 0.
- Reset mid-pending: assert rst while busy=1 in S_RISE_PEND (cnt=2) -> next cycle busy=0, dout=0, glitch_cnt unchanged at 0 (reset value), no rise.
- STABLE_CYCLES=1: din toggles every 3 cycles -> dout follows din delayed by 3 edges; busy is never asserted; one rise/fall pulse per toggle.

Source files
------------

// File: rtl/vs_debounce_pkg.sv
// Shared types and helpers for the vs_debouncer block.
//   vs_db_state_t : debouncer FSM state encoding
//   cnt_width()   : width of a counter that must hold 0..n inclusive
package vs_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_PEND = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_PEND = 2'd3
  } vs_db_state_t;

  // Width needed to hold values 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vs_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronised output (last stage of the chain)
module vs_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/vs_debouncer.sv
// Synchronises and debounces a noisy asynchronous level. A new level is
// accepted only after STABLE_CYCLES consecutive identical synchronised
// samples; shorter excursions are rejected and counted in a saturating
// glitch counter.
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   din        : raw asynchronous input
//   dout       : debounced level (registered)
//   rise       : one-cycle pulse in the cycle dout goes 0->1
//   fall       : one-cycle pulse in the cycle dout goes 1->0
//   busy       : high while a level change awaits qualification
//   glitch_cnt : saturating count of rejected candidate transitions
//   dbg_state  : current FSM state (vs_db_state_t encoding), for observation
module vs_debouncer
  import vs_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  output logic                dout,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic [1:0]          dbg_state
);

  localparam int                 CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  // With a one-sample window a new level is accepted on first sight.
  localparam bit                 SINGLE   = (STABLE_CYCLES == 1);

  logic din_s;

  vs_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  vs_db_state_t        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                glitch_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      glitch_q <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (din_s) begin
          if (SINGLE) begin
            state_d = S_HIGH;
            rise_d  = 1'b1;
          end else begin
            state_d = S_RISE_PEND;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_RISE_PEND: begin
        if (!din_s) begin
          state_d    = S_LOW;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!din_s) begin
          if (SINGLE) begin
            state_d = S_LOW;
            fall_d  = 1'b1;
          end else begin
            state_d = S_FALL_PEND;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_FALL_PEND: begin
        if (din_s) begin
          state_d    = S_HIGH;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    // Saturate rather than wrap so a storm of glitches stays visible.
    glitch_d = glitch_q;
    if (glitch_inc && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  // dout and busy are decoded from the registered state, so they change on
  // the same edge as the registered rise/fall pulses.
  assign dout       = (state_q == S_HIGH) || (state_q == S_FALL_PEND);
  assign busy       = (state_q == S_RISE_PEND) || (state_q == S_FALL_PEND);
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vs_debouncer.sv
// Bench for vs_debouncer. Three instances share one din/rst stream:
//   dut 0 : SYNC_STAGES=2, STABLE_CYCLES=4, GLITCH_W=8 (default)
//   dut 1 : SYNC_STAGES=2, STABLE_CYCLES=1, GLITCH_W=8
//   dut 2 : SYNC_STAGES=3, STABLE_CYCLES=3, GLITCH_W=2 (saturates quickly)
// The driver applies din/rst on the falling edge, steps a run-length model
// of the acceptance rule, and queues the expected outputs; the monitor pops
// one entry per rising edge and compares all three instances.
module tb_vs_debouncer;

  localparam int EW = 12; // dout, rise, fall, busy, 8-bit glitch count

  logic clk;
  logic rst;
  logic din;

  logic       dout_a, rise_a, fall_a, busy_a;
  logic [7:0] gc_a;
  logic [1:0] st_a;
  logic       dout_b, rise_b, fall_b, busy_b;
  logic [7:0] gc_b;
  logic [1:0] st_b;
  logic       dout_c, rise_c, fall_c, busy_c;
  logic [1:0] gc_c;
  logic [1:0] st_c;

  vs_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(8)) dut_a (
    .clk(clk), .rst(rst), .din(din), .dout(dout_a), .rise(rise_a),
    .fall(fall_a), .busy(busy_a), .glitch_cnt(gc_a), .dbg_state(st_a)
  );

  vs_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GLITCH_W(8)) dut_b (
    .clk(clk), .rst(rst), .din(din), .dout(dout_b), .rise(rise_b),
    .fall(fall_b), .busy(busy_b), .glitch_cnt(gc_b), .dbg_state(st_b)
  );

  vs_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(3), .GLITCH_W(2)) dut_c (
    .clk(clk), .rst(rst), .din(din), .dout(dout_c), .rise(rise_c),
    .fall(fall_c), .busy(busy_c), .glitch_cnt(gc_c), .dbg_state(st_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         p_sync [3] = '{2, 2, 3};
  int         p_stab [3] = '{4, 1, 3};
  int         p_gmax [3] = '{255, 255, 3};
  logic [7:0] m_sh   [3];
  logic       m_level[3];
  int         m_run  [3];
  int         m_gc   [3];
  logic       m_rise [3];
  logic       m_fall [3];

  logic [3*EW-1:0] exp_q[$];
  int n_checks;
  int n_pass;
  int n_fail;
  int cyc;

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_sh[k] = '0; m_level[k] = 1'b0; m_run[k] = 0; m_gc[k] = 0;
      m_rise[k] = 1'b0; m_fall[k] = 1'b0;
    end
  end

  // Effect of one rising edge: m_run is the number of consecutive
  // synchronised samples that disagree with the accepted level.
  task automatic model_step(input logic r, input logic d);
    logic s;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_sh[k] = '0; m_level[k] = 1'b0; m_run[k] = 0; m_gc[k] = 0;
        m_rise[k] = 1'b0; m_fall[k] = 1'b0;
      end else begin
        s = m_sh[k][p_sync[k]-1];
        m_sh[k] = {m_sh[k][6:0], d};
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        if (s != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] >= p_stab[k]) begin
            m_level[k] = s;
            m_rise[k]  = s;
            m_fall[k]  = ~s;
            m_run[k]   = 0;
          end
        end else if (m_run[k] > 0) begin
          m_gc[k]  = (m_gc[k] < p_gmax[k]) ? m_gc[k] + 1 : p_gmax[k];
          m_run[k] = 0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic d, input int n);
    logic [3*EW-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r;
      din = d;
      model_step(r, d);
      for (int k = 0; k < 3; k++) begin
        e[k*EW +: EW] = {m_level[k], m_rise[k], m_fall[k], (m_run[k] > 0),
                         8'(m_gc[k])};
      end
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [3*EW-1:0] e;
    logic [EW-1:0]   act[3];
    logic [EW-1:0]   ex;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act[0] = {dout_a, rise_a, fall_a, busy_a, gc_a};
        act[1] = {dout_b, rise_b, fall_b, busy_b, gc_b};
        act[2] = {dout_c, rise_c, fall_c, busy_c, 6'd0, gc_c};
        for (int k = 0; k < 3; k++) begin
          ex = e[k*EW +: EW];
          n_checks++;
          if (act[k] === ex) begin
            n_pass++;
          end else begin
            n_fail++;
            $display("FAIL dut%0d cycle %0d: got dout/rise/fall/busy/glitch=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                     k, cyc, act[k][11], act[k][10], act[k][9], act[k][8],
                     act[k][7:0], ex[11], ex[10], ex[9], ex[8], ex[7:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    logic lvl;
    n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    din = 1'b0;

    // Reset held with din high, then release and let it qualify.
    drive(1'b1, 1'b1, 2);
    drive(1'b0, 1'b1, 10);
    // Clean falling edge.
    drive(1'b0, 1'b0, 10);
    // Clean rising then falling edge from low.
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    // 3-cycle pulse: rejected by dut 0.
    drive(1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 8);
    // 4-cycle pulse: accepted by dut 0.
    drive(1'b0, 1'b1, 4);
    drive(1'b0, 1'b0, 10);
    // Five 2-cycle glitches: dut 2 counter saturates at 3.
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, 1'b1, 2);
      drive(1'b0, 1'b0, 6);
    end
    // Reset while a rise is pending qualification.
    drive(1'b0, 1'b1, 4);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b0, 8);
    // Toggle every 3 cycles.
    for (int t = 0; t < 10; t++) begin
      drive(1'b0, t[0] ? 1'b0 : 1'b1, 3);
    end
    drive(1'b0, 1'b0, 8);
    // Random level runs, with an occasional reset.
    for (int r = 0; r < 400; r++) begin
      len = $urandom_range(1, 8);
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        drive(1'b1, lvl, 1);
      end
      drive(1'b0, lvl, len);
    end
    drive(1'b0, 1'b0, 12);

    // Let the monitor drain the queue, bounded.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
